// File: rtl/contador_ctrl.sv
// contador_ctrl: layer state FSM plus a sequencer that reads the four FIFO counters while the layer is IDLE
module contador_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [3:0] fifo_empty,
    input  logic       rd_start,
    input  logic       valid,
    input  logic [4:0] data_in,
    output logic [3:0] state,
    output logic       req,
    output logic [1:0] idx,
    output logic       busy,
    output logic       rd_done,
    output logic [4:0] cnt_0,
    output logic [4:0] cnt_1,
    output logic [4:0] cnt_2,
    output logic [4:0] cnt_3
);
    typedef enum logic [3:0] {RESET = 4'b0001, INIT = 4'b0010, IDLE = 4'b0100, ACTIVE = 4'b1000} layer_t;
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_REQ, S_WAIT} sched_t;
    layer_t     layer_q, layer_d;
    sched_t     sched_q, sched_d;
    logic [1:0] idx_d;
    logic       busy_d, done_d, cap, is_idle;
    logic [4:0] cnt_q [4];
    assign is_idle = layer_q == IDLE;
    always_comb begin
        case (layer_q)
            RESET:   layer_d = INIT;
            INIT:    layer_d = init ? INIT : IDLE;
            IDLE:    layer_d = init ? INIT : (fifo_empty != 4'hF ? ACTIVE : IDLE);
            ACTIVE:  layer_d = init ? INIT : (fifo_empty == 4'hF ? IDLE : ACTIVE);
            default: layer_d = RESET;
        endcase
    end
    // A missing valid in S_WAIT retries the same index rather than skipping it
    always_comb begin
        sched_d = sched_q;
        idx_d   = idx;
        busy_d  = busy;
        done_d  = 1'b0;
        cap     = 1'b0;
        case (sched_q)
            S_IDLE: if (rd_start) begin
                busy_d  = 1'b1;
                idx_d   = 2'd0;
                sched_d = is_idle ? S_REQ : S_PEND;
            end
            S_PEND: sched_d = is_idle ? S_REQ : S_PEND;
            S_REQ:  sched_d = S_WAIT;
            S_WAIT: begin
                cap = valid;
                if (!valid) sched_d = is_idle ? S_REQ : S_PEND;
                else if (idx != 2'd3) begin
                    idx_d   = idx + 2'd1;
                    sched_d = is_idle ? S_REQ : S_PEND;
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = 2'd0;
                    sched_d = S_IDLE;
                end
            end
            default: sched_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            layer_q <= RESET;
            sched_q <= S_IDLE;
            req     <= 1'b0;
            idx     <= 2'd0;
            busy    <= 1'b0;
            rd_done <= 1'b0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= 5'd0;
        end else begin
            layer_q <= layer_d;
            sched_q <= sched_d;
            req     <= sched_d == S_REQ;
            idx     <= idx_d;
            busy    <= busy_d;
            rd_done <= done_d;
            if (cap) cnt_q[idx] <= data_in;
        end
    end
    assign state = layer_q;
    assign cnt_0 = cnt_q[0];
    assign cnt_1 = cnt_q[1];
    assign cnt_2 = cnt_q[2];
    assign cnt_3 = cnt_q[3];
endmodule

// File: tb/tb_contador_ctrl.sv
// tb_contador_ctrl: directed checks of the layer FSM and counter read sequencing against a simple counter-block model
module tb_contador_ctrl;
    logic       clk = 1'b0;
    logic       reset, init, rd_start;
    logic       valid = 1'b0;
    logic [4:0] data_in = 5'd0;
    logic [3:0] fifo_empty;
    logic [3:0] state;
    logic       req, busy, rd_done;
    logic [1:0] idx;
    logic [4:0] cnt_0, cnt_1, cnt_2, cnt_3;
    logic [4:0] mdl [4];
    int         n_run = 0, n_fail = 0;
    contador_ctrl dut (
        .clk(clk), .reset(reset), .init(init), .fifo_empty(fifo_empty), .rd_start(rd_start),
        .valid(valid), .data_in(data_in), .state(state), .req(req), .idx(idx), .busy(busy),
        .rd_done(rd_done), .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3)
    );
    always #5 clk = ~clk;
    // Counter block answers a request only if the layer stays IDLE through the request cycle
    always @(posedge clk) begin
        valid   <= req && fifo_empty == 4'hF && !init && !reset;
        data_in <= mdl[idx];
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk_cnts(input string tag, input logic [4:0] e0, e1, e2, e3);
        chk({tag, "_cnt0"}, cnt_0, e0);
        chk({tag, "_cnt1"}, cnt_1, e1);
        chk({tag, "_cnt2"}, cnt_2, e2);
        chk({tag, "_cnt3"}, cnt_3, e3);
    endtask
    initial begin
        int n;
        int dones;
        reset = 1'b1; init = 1'b0; rd_start = 1'b0; fifo_empty = 4'hF;
        mdl[0] = 5'd3; mdl[1] = 5'd7; mdl[2] = 5'd0; mdl[3] = 5'd31;
        step(); step();
        chk("rst_state", state, 4'b0001);
        chk("rst_req", req, 0);
        chk("rst_idx", idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", rd_done, 0);
        chk_cnts("rst", 0, 0, 0, 0);
        reset = 1'b0; init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("init_hold", state, 4'b0010);
        end
        init = 1'b0;
        step(); chk("to_idle", state, 4'b0100);
        fifo_empty = 4'b1011;
        step(); chk("to_active", state, 4'b1000);
        fifo_empty = 4'hF;
        step(); chk("back_idle", state, 4'b0100);
        init = 1'b1; fifo_empty = 4'h0;
        step(); chk("init_prio", state, 4'b0010);
        init = 1'b0; fifo_empty = 4'hF;
        step(); chk("idle_again", state, 4'b0100);
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            chk($sformatf("seq_req%0d", c), req, (c % 2 == 0 && c < 8) ? 1 : 0);
            chk($sformatf("seq_idx%0d", c), idx, c < 8 ? c / 2 : 0);
            chk($sformatf("seq_busy%0d", c), busy, c < 8 ? 1 : 0);
            chk($sformatf("seq_done%0d", c), rd_done, c == 8 ? 1 : 0);
            if (c < 8) step();
        end
        chk_cnts("seq", 3, 7, 0, 31);
        step(); chk("done_pulse", rd_done, 0);
        mdl[0] = 5'd9; mdl[1] = 5'd12; mdl[2] = 5'd25; mdl[3] = 5'd1;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step(); step();
        chk("retry_req_idx1", req, 1);
        chk("retry_idx1", idx, 1);
        fifo_empty = 4'b1110;
        step();
        chk("retry_active", state, 4'b1000);
        chk("retry_wait_idx", idx, 1);
        step(); step();
        chk("retry_pend_req", req, 0);
        chk("retry_pend_idx", idx, 1);
        chk("retry_pend_busy", busy, 1);
        chk("retry_cnt1_kept", cnt_1, 7);
        fifo_empty = 4'hF;
        n = 0;
        while (!req && n < 20) begin step(); n++; end
        chk("rereq_seen", req, 1);
        chk("rereq_idx", idx, 1);
        n = 0;
        while (!rd_done && n < 40) begin step(); n++; end
        chk("retry_done", rd_done, 1);
        chk_cnts("retry", 9, 12, 25, 1);
        mdl[0] = 5'd4; mdl[1] = 5'd5; mdl[2] = 5'd6; mdl[3] = 5'd8;
        step();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        step();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        chk("busy_ignore_req", req, 1);
        chk("busy_ignore_idx", idx, 1);
        step(); step(); step();
        chk("abort_wait_idx", idx, 2);
        chk("abort_wait_req", req, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_state", state, 4'b0001);
        chk("abort_req", req, 0);
        chk("abort_idx", idx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", rd_done, 0);
        chk_cnts("abort", 0, 0, 0, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rd_done || req) dones++;
        end
        chk("abort_no_activity", dones, 0);
        chk("abort_busy_after", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
